// File: rtl/drum_pkg.sv
// Shared types for the drum sample player: sample width, signed sample
// type, player state encoding and the optional gain attenuator.
package drum_pkg;

   localparam int SAMPLE_W = 24;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      PLAY
   } player_state_t;

   function automatic sample_t attenuate(sample_t d, logic [1:0] g);
      return d >>> g;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one-cycle pulse on a 0->1 transition.
module rise_detect (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/sample_player.sv
// One-shot drum sample player streaming an external ROM to the codec.
// Optional output attenuation is enabled with SAMPLE_PLAYER_GAIN_EN.
module sample_player
   import drum_pkg::*;
#(
   parameter int SAMPLE_LEN = 12000,
   parameter int ADDR_W     = 14
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              trigger,
   input  logic              sample_req,
`ifdef SAMPLE_PLAYER_GAIN_EN
   input  logic [1:0]        gain,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic [23:0]       wav,
   output logic              wav_strobe,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(SAMPLE_LEN - 1);
   localparam logic [ADDR_W-1:0] FIRST = (SAMPLE_LEN > 1) ? ADDR_W'(1) : '0;

   player_state_t     state, state_d;
   logic [ADDR_W-1:0] idx, idx_d;
   logic [ADDR_W-1:0] addr_d;
   sample_t           wav_q, wav_d;
   logic              strobe_d;
   logic              req_rise;
   sample_t           level;

   rise_detect u_rise (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .d        (sample_req),
      .rise     (req_rise)
   );

`ifdef SAMPLE_PLAYER_GAIN_EN
   assign level = attenuate(sample_t'(rom_data), gain);
`else
   assign level = sample_t'(rom_data);
`endif

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         rom_addr   <= '0;
         wav_q      <= '0;
         wav_strobe <= 1'b0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         rom_addr   <= addr_d;
         wav_q      <= wav_d;
         wav_strobe <= strobe_d;
      end
   end

   // Trigger outranks everything, including a same-cycle request edge.
   always_comb begin
      state_d  = state;
      idx_d    = idx;
      addr_d   = rom_addr;
      wav_d    = wav_q;
      strobe_d = 1'b0;
      priority case (1'b1)
         trigger: begin
            state_d = PRIME;
            addr_d  = '0;
         end
         state == PRIME: begin
            wav_d    = level;
            strobe_d = 1'b1;
            idx_d    = '0;
            addr_d   = FIRST;
            state_d  = PLAY;
         end
         state == PLAY && req_rise: begin
            strobe_d = 1'b1;
            if (idx == LAST) begin
               wav_d   = '0;
               addr_d  = '0;
               state_d = IDLE;
            end else begin
               wav_d  = level;
               idx_d  = idx + 1'b1;
               addr_d = (rom_addr == LAST) ? LAST : rom_addr + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign wav  = wav_q;
   assign busy = (state != IDLE);

endmodule

// File: doc/sample_player.md
SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 SHALL have parameter SAMPLE_LEN, default 12000, number of samples in the drum hit (0.25 s at 48 kHz).
REQ-002 SHALL have parameter ADDR_W, default 14, sample ROM address width; SAMPLE_LEN <= 2**ADDR_W.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port trigger  input  1  one-cycle pulse starting or restarting the hit.
REQ-006 SHALL have port sample_req  input  1  codec write-ready level; each rising edge requests the next sample.
REQ-007 SHALL have port rom_addr  output  ADDR_W  registered sample ROM address.
REQ-008 SHALL have port rom_data  input  24  ROM read data, valid one cycle after rom_addr changes.
REQ-009 SHALL have port wav  output  24  signed two's-complement sample, fed to the step gate downstream.
REQ-010 SHALL have port wav_strobe  output  1  one-cycle pulse when wav takes a new value.
REQ-011 SHALL have port busy  output  1  high while a hit is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, PRIME, PLAY.
REQ-013 IDLE: wav = 0, rom_addr = 0, busy = 0; trigger -> PRIME.
REQ-014 PRIME: lasts exactly one cycle with rom_addr = 0, then sets wav <= rom_data, pulses wav_strobe, sets idx <= 0, sets rom_addr <= 1, and moves to PLAY.
REQ-015 PLAY: on a sample_req rising edge with idx < SAMPLE_LEN-1, SHALL set wav <= rom_data, pulse wav_strobe, and increment idx and rom_addr.
REQ-016 PLAY: on a sample_req rising edge with idx == SAMPLE_LEN-1, SHALL set wav <= 0, pulse wav_strobe, set rom_addr <= 0, and return to IDLE.
REQ-017 SHALL ensure rom_addr never exceeds SAMPLE_LEN-1; the prefetch at the last index holds at SAMPLE_LEN-1.
REQ-018 On trigger in PRIME or PLAY, SHALL restart: rom_addr <= 0, go to PRIME, wav holds its value until PRIME completes.
REQ-019 If trigger and a sample_req edge occur in the same cycle, trigger SHALL win and the request is dropped.
REQ-020 Sample_req edges in IDLE or PRIME SHALL be ignored, with no strobe.
REQ-021 busy SHALL be 1 in PRIME and PLAY.
REQ-022 Latency: wav SHALL update on the clock edge following the cycle in which the rising edge is detected.

Reset
REQ-023 On reset = 0, SHALL asynchronously force state IDLE, wav = 0, wav_strobe = 0, busy = 0, rom_addr = 0, idx = 0, and clear the edge-detect history.
REQ-024 Reset asserted mid-hit SHALL abandon the hit; after release, no sample is emitted until a new trigger.

Configuration
REQ-025 SHALL gate the feature under macro SAMPLE_PLAYER_GAIN_EN; when defined, add input port gain (2 bits), and set wav = rom_data arithmetic-shifted right by gain (0 = full level, 3 = 1/8), sign preserved.
REQ-026 SHALL, without SAMPLE_PLAYER_GAIN_EN, omit the gain port and pass rom_data to wav unmodified.

Structure
REQ-027 Package drum_pkg SHALL hold SAMPLE_W = 24, typedef sample_t (signed 24-bit), and the player state enum.
REQ-028 SHALL implement rising-edge detection of sample_req in sub-module rise_detect (1-bit in, 1-cycle pulse out, async active-low reset).
REQ-029 SHALL keep the ROM itself external to the module.

Verification
REQ-030 Bench SHALL cover normal hit: ROM[i] = i+1, SAMPLE_LEN = 4, trigger, then 5 req edges -> wav sequence 1,2,3,4,0, five strobes, busy falls with the 0.
REQ-031 Bench SHALL cover retrigger: trigger, 2 req edges (wav = 2), trigger -> wav holds 2 through PRIME, then wav = 1, rom_addr = 1.
REQ-032 Bench SHALL cover collision: trigger and a req edge in the same cycle during PLAY -> no strobe from the req, restart to sample 1.
REQ-033 Bench SHALL cover level hold: sample_req held high 10 cycles in PLAY -> exactly one strobe.
REQ-034 Bench SHALL cover reset mid-hit: reset = 0 at idx = 2 -> wav = 0 and busy = 0 immediately, before the next clock edge; later req edges give no strobe.
REQ-035 Bench SHALL cover gain (with SAMPLE_PLAYER_GAIN_EN): rom_data = 24'h800000, gain = 2 -> wav = 24'hE00000.
